// File: rtl/eth_fifo_pkg.sv
// Shared types and constants for the Ethernet FIFO read path.
package eth_fifo_pkg;

    localparam int unsigned FRAME_CNT_W = 16;
    localparam int unsigned BUF_DEPTH   = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } rd_state_e;

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// FIFO read-side and AXI-Stream master signals of fifo_rd_ctrl.
interface fifo_rd_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 8
) ();

    logic                  fifo_empty;
    logic                  fifo_rd;
    logic [DATA_WIDTH:0]   fifo_rd_data;
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tlast;
    logic                  m_axis_tready;

    modport master (
        input  fifo_empty,
        input  fifo_rd_data,
        input  m_axis_tready,
        output fifo_rd,
        output m_axis_tdata,
        output m_axis_tvalid,
        output m_axis_tlast
    );

    modport slave (
        output fifo_empty,
        output fifo_rd_data,
        output m_axis_tready,
        input  fifo_rd,
        input  m_axis_tdata,
        input  m_axis_tvalid,
        input  m_axis_tlast
    );

endinterface

// File: rtl/axis_skid_buf.sv
// Two-entry in-order output buffer; head entry drives the stream.
// rd_en is only asserted while valid, and wr_en never arrives when full without rd_en.
module axis_skid_buf #(
    parameter int unsigned WIDTH = 9
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic [1:0]       occ
);

    logic [WIDTH-1:0] ent0_q;
    logic [WIDTH-1:0] ent1_q;
    logic [1:0]       occ_q;

    // ent0 is always the head; ent1 only holds data when two words are buffered
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ent0_q <= '0;
            ent1_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            case ({wr_en, rd_en})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        ent0_q <= wr_data;
                    end else begin
                        ent1_q <= wr_data;
                    end
                    occ_q <= occ_q + 2'd1;
                end
                2'b01: begin
                    ent0_q <= ent1_q;
                    occ_q  <= occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        ent0_q <= wr_data;
                    end else begin
                        ent0_q <= ent1_q;
                        ent1_q <= wr_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign head  = ent0_q;
    assign valid = (occ_q != 2'd0);
    assign occ   = occ_q;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Pulls frames from a registered-empty FIFO and presents them as an AXI-Stream master.
// Build option FRAME_CNT_EN adds a 16-bit wrapping count of completed frames.
module fifo_rd_ctrl
    import eth_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    fifo_rd_ctrl_if.master bus,
    input  logic           enable,
    output logic           busy
`ifdef FRAME_CNT_EN
    ,
    output logic [FRAME_CNT_W-1:0] frame_cnt
`endif
);

    localparam int unsigned WORD_W = DATA_WIDTH + 1;

    rd_state_e         state_q;
    rd_state_e         state_d;
    logic              pend_q;
    logic [1:0]        occ;
    logic [WORD_W-1:0] head;
    logic              pop_c;
    logic              rd_c;
    logic              eof_ret_c;
    logic              room_c;
    logic              busy_d;
    logic [2:0]        after_pop_c;

    assign pop_c     = bus.m_axis_tvalid & bus.m_axis_tready;
    assign eof_ret_c = pend_q & bus.fifo_rd_data[DATA_WIDTH];

    // Words owned after this cycle: buffered + in flight - leaving; must stay below 2 to read
    assign after_pop_c = 3'(occ) + 3'(pend_q) - 3'(pop_c);
    assign room_c      = (after_pop_c < 3'(BUF_DEPTH));

    // Read issue and frame FSM; busy_d is what busy must show next cycle
    always_comb begin
        state_d = state_q;
        rd_c    = 1'b0;
        busy_d  = 1'b0;

        rd_c = reset_n & ~bus.fifo_empty & ((state_q == ACTIVE) | enable) & room_c;

        case (state_q)
            IDLE: begin
                if (rd_c) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                // a read overlapping the EOF return opens the next frame
                if (eof_ret_c && !rd_c) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == ACTIVE) | rd_c | (after_pop_c != 3'd0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pend_q  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= rd_c;
            busy    <= busy_d;
        end
    end

    assign bus.fifo_rd = rd_c;

    axis_skid_buf #(
        .WIDTH(WORD_W)
    ) u_buf (
        .clk    (clk),
        .reset_n(reset_n),
        .wr_en  (pend_q),
        .wr_data(bus.fifo_rd_data),
        .rd_en  (pop_c),
        .head   (head),
        .valid  (bus.m_axis_tvalid),
        .occ    (occ)
    );

    assign bus.m_axis_tdata = head[DATA_WIDTH-1:0];
    assign bus.m_axis_tlast = head[DATA_WIDTH];

`ifdef FRAME_CNT_EN
    // Counts accepted end-of-frame beats, wrapping naturally
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt <= '0;
        end else if (pop_c && bus.m_axis_tlast) begin
            frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
        end
    end
`endif

    a_no_underflow: assert property (@(posedge clk) disable iff (!reset_n)
        bus.fifo_rd |-> !bus.fifo_empty);

    a_owned_bound: assert property (@(posedge clk) disable iff (!reset_n)
        (3'(occ) + 3'(pend_q)) <= 3'(BUF_DEPTH));

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl: FIFO model, scoreboard, vector table and corner sequences.
module tb_fifo_rd_ctrl;
    import eth_fifo_pkg::*;

    localparam int unsigned DW = 8;

    logic clk = 1'b0;
    logic reset_n;
    logic enable;
    logic busy;
`ifdef FRAME_CNT_EN
    logic [FRAME_CNT_W-1:0] frame_cnt;
`endif

    fifo_rd_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    fifo_rd_ctrl #(
        .DATA_WIDTH(DW)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus),
        .enable (enable),
        .busy   (busy)
`ifdef FRAME_CNT_EN
        ,
        .frame_cnt(frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int         len;
        logic [7:0] base;
        bit         rnd;
        int         exp_beats;
        int         exp_lasts;
        int         exp_rds;
    } vec_t;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rd_cnt = 0;
    int beats = 0;
    int lasts = 0;
    int first_rd_cyc = -1;
    int tv_log[$];
    logic [DW:0] fifo_q[$];
    logic [DW:0] exp_q[$];
    bit rnd_ready = 1'b0;
    bit toggle_en = 1'b0;
    bit prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic prev_last = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_word(input logic [7:0] d, input logic l);
        logic [DW:0] w;
        w = {l, d};
        fifo_q.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic push_frame(input int len, input logic [7:0] base);
        for (int i = 0; i < len; i++) begin
            push_word(base + 8'(i), (i == len - 1));
        end
    endtask

    // One clock: monitor at negedge, FIFO model and input drive just after posedge
    task automatic tick();
        logic rd_s;
        logic [DW:0] w;
        @(negedge clk);
        rd_s = bus.fifo_rd;
        if (rd_s) begin
            rd_cnt++;
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
            chk("no_rd_when_empty", 32'(bus.fifo_empty), 32'd0);
        end
        if (reset_n) begin
            if (bus.m_axis_tvalid) tv_log.push_back(cyc);
            if (prev_stall && bus.m_axis_tvalid) begin
                chk("hold_tdata", 32'(bus.m_axis_tdata), 32'(prev_data));
                chk("hold_tlast", 32'(bus.m_axis_tlast), 32'(prev_last));
            end
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got tdata %0h expected no beat (cycle %0d)",
                             bus.m_axis_tdata, cyc);
                end else begin
                    w = exp_q.pop_front();
                    chk("beat_data", 32'(bus.m_axis_tdata), 32'(w[DW-1:0]));
                    chk("beat_last", 32'(bus.m_axis_tlast), 32'(w[DW]));
                end
                beats++;
                if (bus.m_axis_tlast) lasts++;
            end
            prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready;
            prev_data  = bus.m_axis_tdata;
            prev_last  = bus.m_axis_tlast;
        end else begin
            prev_stall = 1'b0;
        end
        @(posedge clk);
        cyc++;
        #1;
        if (rd_s && fifo_q.size() > 0) bus.fifo_rd_data = fifo_q.pop_front();
        bus.fifo_empty = (fifo_q.size() == 0) || (toggle_en && !bus.fifo_empty);
        if (rnd_ready) bus.m_axis_tready = 1'($urandom_range(0, 1));
    endtask

    task automatic drain(input int budget, input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            tick();
            n++;
        end
        chk(name, 32'(exp_q.size() == 0 && !busy), 32'd1);
    endtask

    task automatic wait_tvalid(input int budget);
        int n;
        n = 0;
        while (!bus.m_axis_tvalid && n < budget) begin
            tick();
            n++;
        end
        chk("tvalid_timeout", 32'(bus.m_axis_tvalid), 32'd1);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        int   n;

        vecs[0] = '{len: 1, base: 8'hA0, rnd: 1'b0, exp_beats: 1, exp_lasts: 1, exp_rds: 1};
        vecs[1] = '{len: 3, base: 8'hB0, rnd: 1'b1, exp_beats: 3, exp_lasts: 1, exp_rds: 3};
        vecs[2] = '{len: 7, base: 8'hC0, rnd: 1'b1, exp_beats: 7, exp_lasts: 1, exp_rds: 7};
        vecs[3] = '{len: 2, base: 8'hD0, rnd: 1'b0, exp_beats: 2, exp_lasts: 1, exp_rds: 2};

        reset_n           = 1'b0;
        enable            = 1'b0;
        bus.fifo_empty    = 1'b1;
        bus.fifo_rd_data  = '0;
        bus.m_axis_tready = 1'b0;

        // reset state, before any clock edge
        #2;
        chk("rst_fifo_rd", 32'(bus.fifo_rd), 32'd0);
        chk("rst_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
        chk("rst_tlast", 32'(bus.m_axis_tlast), 32'd0);
        chk("rst_tdata", 32'(bus.m_axis_tdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;

        // 4-word frame, free-flowing output
        enable = 1'b1;
        bus.m_axis_tready = 1'b1;
        rd_cnt = 0;
        first_rd_cyc = -1;
        tv_log.delete();
        push_word(8'h11, 1'b0);
        push_word(8'h22, 1'b0);
        push_word(8'h33, 1'b0);
        push_word(8'h44, 1'b1);
        drain(30, "basic_drain");
        tick();
        tick();
        chk("basic_rd_count", 32'(rd_cnt), 32'd4);
        chk("basic_tvalid_cycles", 32'(tv_log.size()), 32'd4);
        for (int i = 0; i < tv_log.size() && i < 4; i++) begin
            chk("basic_tvalid_at", 32'(tv_log[i]), 32'(first_rd_cyc + 2 + i));
        end
        chk("basic_idle", 32'(dut.state_q), 32'(IDLE));
        chk("basic_busy", 32'(busy), 32'd0);

        // downstream stalls for 5 cycles from first tvalid
        bus.m_axis_tready = 1'b0;
        rd_cnt = 0;
        push_word(8'h11, 1'b0);
        push_word(8'h22, 1'b0);
        push_word(8'h33, 1'b0);
        push_word(8'h44, 1'b1);
        wait_tvalid(20);
        repeat (4) tick();
        chk("stall_rd_count", 32'(rd_cnt), 32'd2);
        chk("stall_head", 32'(bus.m_axis_tdata), 32'h11);
        tick();
        bus.m_axis_tready = 1'b1;
        drain(30, "stall_drain");
        chk("stall_rd_total", 32'(rd_cnt), 32'd4);

        // enable low in IDLE blocks reads; dropping it mid-frame does not
        enable = 1'b0;
        rd_cnt = 0;
        push_frame(4, 8'h50);
        repeat (8) tick();
        chk("en_low_no_rd", 32'(rd_cnt), 32'd0);
        chk("en_low_no_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
        enable = 1'b1;
        n = 0;
        while (rd_cnt == 0 && n < 10) begin
            tick();
            n++;
        end
        enable = 1'b0;
        drain(30, "en_drop_drain");
        chk("en_drop_rd_total", 32'(rd_cnt), 32'd4);
        push_frame(2, 8'h60);
        repeat (8) tick();
        chk("en_drop_no_new_frame", 32'(rd_cnt), 32'd4);
        chk("en_drop_idle_busy", 32'(busy), 32'd0);
        enable = 1'b1;
        drain(30, "en_resume_drain");

        // FIFO empty flag toggling every cycle mid-frame
        toggle_en = 1'b1;
        push_frame(6, 8'h70);
        drain(60, "toggle_drain");
        toggle_en = 1'b0;
        tick();

        // vector table of frames
        for (int v = 0; v < 4; v++) begin
            beats = 0;
            lasts = 0;
            rd_cnt = 0;
            rnd_ready = vecs[v].rnd;
            bus.m_axis_tready = 1'b1;
            push_frame(vecs[v].len, vecs[v].base);
            drain(200, "vec_drain");
            rnd_ready = 1'b0;
            bus.m_axis_tready = 1'b1;
            chk("vec_beats", 32'(beats), 32'(vecs[v].exp_beats));
            chk("vec_lasts", 32'(lasts), 32'(vecs[v].exp_lasts));
            chk("vec_rds", 32'(rd_cnt), 32'(vecs[v].exp_rds));
            chk("vec_busy", 32'(busy), 32'd0);
        end

        // reset with two words buffered and a read being issued
        bus.m_axis_tready = 1'b0;
        push_frame(4, 8'h80);
        wait_tvalid(20);
        tick();
        bus.m_axis_tready = 1'b1;
        #1;
        chk("pre_rst_rd", 32'(bus.fifo_rd), 32'd1);
        chk("pre_rst_head", 32'(bus.m_axis_tdata), 32'h80);
        #1;
        reset_n = 1'b0;
        #1;
        chk("arst_fifo_rd", 32'(bus.fifo_rd), 32'd0);
        chk("arst_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
        chk("arst_tlast", 32'(bus.m_axis_tlast), 32'd0);
        chk("arst_tdata", 32'(bus.m_axis_tdata), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        fifo_q.delete();
        exp_q.delete();
        tick();
        tick();
        chk("rst_hold_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
        reset_n = 1'b1;
        push_frame(3, 8'h90);
        drain(30, "post_rst_drain");
        chk("post_rst_idle", 32'(dut.state_q), 32'(IDLE));

`ifdef FRAME_CNT_EN
        // frame counter: three 1-word frames, then wrap at 0xFFFF
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("fcnt_reset", 32'(frame_cnt), 32'd0);
        bus.m_axis_tready = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 3; i++) push_word(8'(i), 1'b1);
        drain(30, "fcnt_drain3");
        chk("fcnt_three", 32'(frame_cnt), 32'd3);
        for (int i = 0; i < 65532; i++) push_word(8'(i), 1'b1);
        drain(70000, "fcnt_drain_bulk");
        chk("fcnt_max", 32'(frame_cnt), 32'hFFFF);
        push_word(8'hEE, 1'b1);
        drain(30, "fcnt_drain_wrap");
        chk("fcnt_wrap", 32'(frame_cnt), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
